// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s.
// Define BIT_STUFFER_BYPASS_EN to add a bypass input that forwards data unstuffed.
module bit_stuffer #(
    parameter int STUFF_LEN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic rollover_flag64,
`ifdef BIT_STUFFER_BYPASS_EN
    input  logic bypass,
`endif
    output logic stuffing,
    output logic stuffed_serial_out
);

    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(STUFF_LEN);

    logic [CW-1:0] ones_q, ones_d;
    logic          out_q, out_d;
    logic          stuff_q, stuff_d;
    logic          byp;

`ifdef BIT_STUFFER_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        ones_d = ones_q;
        out_d  = out_q;
        if (byp) begin
            ones_d = '0;
            if (rollover_flag64) begin
                out_d = serial_in;
            end
        end else if (rollover_flag64) begin
            if (ones_q == RUN_MAX) begin
                // Emit the stuffed 0; serial_in is held upstream and resampled.
                out_d  = 1'b0;
                ones_d = '0;
            end else begin
                out_d  = serial_in;
                ones_d = serial_in ? ones_q + CW'(1) : '0;
            end
        end
        stuff_d = (ones_d == RUN_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q  <= '0;
            out_q   <= 1'b1;
            stuff_q <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            out_q   <= out_d;
            stuff_q <= stuff_d;
        end
    end

    assign stuffing           = stuff_q & ~byp;
    assign stuffed_serial_out = out_q;

endmodule

// File: tb/tb_bit_stuffer.sv
// Randomized scoreboard bench for bit_stuffer.
// A stream-level model predicts output bits and the stuffing look-ahead.
module tb_bit_stuffer;

    localparam int L = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b0;
    logic rollover_flag64 = 1'b0;
    logic stuffing;
    logic stuffed_serial_out;
`ifdef BIT_STUFFER_BYPASS_EN
    logic bypass = 1'b0;
`endif

    bit_stuffer #(.STUFF_LEN(L)) dut (
        .clk                (clk),
        .rst                (rst),
        .serial_in          (serial_in),
        .rollover_flag64    (rollover_flag64),
`ifdef BIT_STUFFER_BYPASS_EN
        .bypass             (bypass),
`endif
        .stuffing           (stuffing),
        .stuffed_serial_out (stuffed_serial_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit st;
    } exp_t;

    exp_t expq[$];
    int   passed = 0;
    int   total  = 0;
    int   run    = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Stream model: each data bit is emitted; a completed run of L ones
    // raises the look-ahead and is followed by an extra 0.
    task automatic model(input bit bits[$]);
        foreach (bits[i]) begin
            exp_t e;
            run   = bits[i] ? run + 1 : 0;
            e.b   = bits[i];
            e.st  = (run == L);
            expq.push_back(e);
            if (run == L) begin
                e.b  = 1'b0;
                e.st = 1'b0;
                expq.push_back(e);
                run  = 0;
            end
        end
    endtask

    // Upstream serializer: random boundary spacing, holds its bit while stuffing.
    task automatic send(input bit bits[$], input bit flush);
        int idx = 0;
        int guard = 0;
        model(bits);
        forever begin
            @(negedge clk);
            if (idx >= bits.size() && !(flush && stuffing)) break;
            if (guard > 2000) begin
                chk("send_timeout", guard, 0);
                break;
            end
            guard++;
            serial_in = (idx < bits.size()) ? bits[idx] : 1'b0;
            rollover_flag64 = ($urandom_range(0, 2) == 0);
            if (rollover_flag64 && !stuffing) idx++;
        end
        rollover_flag64 = 1'b0;
        if (flush) chk("drained", expq.size(), 0);
    endtask

    function automatic void word(input logic [31:0] v, input int n, output bit q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(v[i]);
    endfunction

    // Monitor: every boundary outside reset yields one scoreboard entry.
    always @(posedge clk) begin
        if (!rst && rollover_flag64) begin
            #1;
            if (expq.size() == 0) begin
                chk("extra_bit", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("out", int'(stuffed_serial_out), int'(e.b));
                chk("stuffing", int'(stuffing), int'(e.st));
            end
        end
    end

    initial begin
        bit q[$];
        // Reset with active-looking inputs must stay idle.
        rollover_flag64 = 1'b1;
        serial_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_out", int'(stuffed_serial_out), 1);
            chk("rst_stuffing", int'(stuffing), 0);
        end
        rst = 1'b0;
        rollover_flag64 = 1'b0;

        word(32'hD5, 8, q);
        send(q, 1'b1);
        word(32'hFE, 8, q);
        send(q, 1'b1);
        q = {1'b0};
        for (int i = 0; i < 12; i++) q.push_back(1'b1);
        send(q, 1'b1);
        word(32'h1F, 6, q);
        send(q, 1'b1);
        word(32'h3F, 7, q);
        send(q, 1'b1);

        for (int p = 0; p < 25; p++) begin
            int n = $urandom_range(1, 30);
            q = {};
            for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 3) != 0);
            send(q, 1'b1);
        end

        // Reset while a stuff bit is pending.
        q = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        send(q, 1'b0);
        chk("pending_stuffing", int'(stuffing), 1);
        chk("pending_left", expq.size(), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_stuffing", int'(stuffing), 0);
        chk("async_out", int'(stuffed_serial_out), 1);
        expq.delete();
        run = 0;
        @(negedge clk);
        rst = 1'b0;
        q = {1'b1, 1'b0, 1'b1};
        send(q, 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
